// File: rtl/ram_2r1w_clr_pkg.sv
// Shared definitions for the 2-read/1-write register RAM with hardware clear.
package ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_e;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/ram_2r1w_clr_if.sv
// Write, read, debug and clear signals of the 2R1W RAM.
interface ram_2r1w_clr_if #(
   parameter int DATA_W = 11,
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr_1;
   logic [ADDR_W-1:0] rd_addr_2;
   logic [DATA_W-1:0] rd_data_1;
   logic [DATA_W-1:0] rd_data_2;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;
   logic              wr_err;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, dbg_addr, clr_req,
      input  rd_data_1, rd_data_2, dbg_data, clr_busy, clr_done, wr_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, dbg_addr, clr_req,
      output rd_data_1, rd_data_2, dbg_data, clr_busy, clr_done, wr_err
   );
endinterface

// File: rtl/ram_2r1w_clr_row.sv
// One storage row: DATA_W register with write select and synchronous clear.
module ram_row #(
   parameter int DATA_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              clr,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   // clr and we are mutually exclusive by construction; clr wins regardless.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   q <= '0;
      else if (clr) q <= '0;
      else if (we)  q <= d;
   end

endmodule

// File: rtl/ram_2r1w_clr.sv
// Two-read / one-write register RAM with a sequential row-by-row hardware clear
// and a debug read port; read ports are combinational or registered (write-first).
module ram_2r1w_clr
   import ram_pkg::*;
#(
   parameter int DATA_W = 11,
   parameter int ADDR_W = 3,
   parameter int RD_REG = 0
) (
   input  logic          clk,
   input  logic          reset,
   ram_2r1w_clr_if.slave bus
);

   localparam int DEPTH = depth_of(ADDR_W);
   localparam int CNT_W = ADDR_W + 1;

   clr_state_e                   state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         busy, done, err;
   logic                         wr_acc, clr_act;
   logic [DEPTH-1:0]             wr_sel, clr_sel;
   logic [DEPTH-1:0][DATA_W-1:0] row_q;
   logic [DATA_W-1:0]            rd_arr_1, rd_arr_2;

   // Writes are only taken in IDLE; anything else is rejected and flagged.
   assign wr_acc  = bus.wr_en && (state_q == ST_IDLE);
   assign clr_act = (state_q == ST_CLEAR);
   assign wr_sel  = wr_acc  ? (DEPTH'(1) << bus.wr_addr)           : '0;
   assign clr_sel = clr_act ? (DEPTH'(1) << cnt_q[ADDR_W-1:0])      : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            busy  = 1'b1;
            err   = bus.wr_en;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DEPTH - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            err     = bus.wr_en;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.clr_busy = busy;
   assign bus.clr_done = done;
   assign bus.wr_err   = err;

   for (genvar i = 0; i < DEPTH; i++) begin : g_row
      ram_row #(.DATA_W(DATA_W)) u_row (
         .clk   (clk),
         .reset (reset),
         .we    (wr_sel[i]),
         .clr   (clr_sel[i]),
         .d     (bus.wr_data),
         .q     (row_q[i])
      );
   end

   assign rd_arr_1     = row_q[bus.rd_addr_1];
   assign rd_arr_2     = row_q[bus.rd_addr_2];
   assign bus.dbg_data = row_q[bus.dbg_addr];

   if (RD_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] rd_q_1, rd_q_2;

      // Write-first: an accepted write to the addressed row is forwarded.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_q_1 <= '0;
            rd_q_2 <= '0;
         end else begin
            rd_q_1 <= (wr_acc && (bus.wr_addr == bus.rd_addr_1)) ? bus.wr_data : rd_arr_1;
            rd_q_2 <= (wr_acc && (bus.wr_addr == bus.rd_addr_2)) ? bus.wr_data : rd_arr_2;
         end
      end

      assign bus.rd_data_1 = rd_q_1;
      assign bus.rd_data_2 = rd_q_2;
   end else begin : g_rd_comb
      assign bus.rd_data_1 = rd_arr_1;
      assign bus.rd_data_2 = rd_arr_2;
   end

endmodule

// File: tb/tb_ram_2r1w_clr.sv
// Directed bench for ram_2r1w_clr: combinational, registered and wide variants.
module tb_ram_2r1w_clr;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ram_2r1w_clr_if #(.DATA_W(11), .ADDR_W(3)) i0 ();
   ram_2r1w_clr_if #(.DATA_W(11), .ADDR_W(3)) i1 ();
   ram_2r1w_clr_if #(.DATA_W(16), .ADDR_W(5)) i2 ();

   ram_2r1w_clr #(.DATA_W(11), .ADDR_W(3), .RD_REG(0)) u_comb (.clk(clk), .reset(reset), .bus(i0));
   ram_2r1w_clr #(.DATA_W(11), .ADDR_W(3), .RD_REG(1)) u_reg  (.clk(clk), .reset(reset), .bus(i1));
   ram_2r1w_clr #(.DATA_W(16), .ADDR_W(5), .RD_REG(0)) u_wide (.clk(clk), .reset(reset), .bus(i2));

   // The registered-read instance mirrors the stimulus of the combinational one.
   assign i1.wr_en     = i0.wr_en;
   assign i1.wr_addr   = i0.wr_addr;
   assign i1.wr_data   = i0.wr_data;
   assign i1.rd_addr_1 = i0.rd_addr_1;
   assign i1.rd_addr_2 = i0.rd_addr_2;
   assign i1.dbg_addr  = i0.dbg_addr;
   assign i1.clr_req   = i0.clr_req;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic logic [10:0] fv(input int i);
      return 11'(i * 37 + 5);
   endfunction

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic compare(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: observed %h with no expectation", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic wait_idle0(input string tag);
      int n = 0;
      while (i0.clr_busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      #1;
      expect_v(tag, 32'd0);
      compare(32'(i0.clr_busy));
   endtask

   task automatic wr0(input logic en, input logic [2:0] a, input logic [10:0] d);
      i0.wr_en   = en;
      i0.wr_addr = a;
      i0.wr_data = d;
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;

      reset = 1'b0;
      wr0(1'b0, 3'd0, 11'd0);
      i0.rd_addr_1 = 3'd0; i0.rd_addr_2 = 3'd0; i0.dbg_addr = 3'd0; i0.clr_req = 1'b0;
      i2.wr_en = 1'b0; i2.wr_addr = 5'd0; i2.wr_data = 16'd0;
      i2.rd_addr_1 = 5'd0; i2.rd_addr_2 = 5'd0; i2.dbg_addr = 5'd0; i2.clr_req = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      expect_v("rst_busy", 32'd0); expect_v("rst_done", 32'd0); expect_v("rst_werr", 32'd0);
      expect_v("rst_rdreg", 32'd0); expect_v("rst_dbg_wide", 32'd0);
      #1;
      compare(32'(i0.clr_busy)); compare(32'(i0.clr_done)); compare(32'(i0.wr_err));
      compare(32'(i1.rd_data_1)); compare(32'(i2.dbg_data));

      // Basic writes/reads, first edge after release accepts the write
      @(negedge clk);
      reset = 1'b1;
      wr0(1'b1, 3'd2, 11'h5A3); i0.rd_addr_1 = 3'd2; i0.rd_addr_2 = 3'd7;
      expect_v("comb_old_data", 32'd0); expect_v("reg_pre", 32'd0);
      #1; compare(32'(i0.rd_data_1)); compare(32'(i1.rd_data_1));

      @(negedge clk);
      wr0(1'b1, 3'd7, 11'h7FF);
      expect_v("comb_rd1_row2", 32'h5A3); expect_v("comb_rd2_old", 32'd0);
      expect_v("reg_rd1_bypass", 32'h5A3); expect_v("reg_rd2_row7", 32'd0);
      #1; compare(32'(i0.rd_data_1)); compare(32'(i0.rd_data_2));
      compare(32'(i1.rd_data_1)); compare(32'(i1.rd_data_2));

      @(negedge clk);
      wr0(1'b0, 3'd0, 11'd0);
      expect_v("comb_rd1", 32'h5A3); expect_v("comb_rd2", 32'h7FF); expect_v("reg_rd2_bypass", 32'h7FF);
      #1; compare(32'(i0.rd_data_1)); compare(32'(i0.rd_data_2)); compare(32'(i1.rd_data_2));

      @(negedge clk);
      i0.rd_addr_2 = 3'd2;
      expect_v("same_addr_rd1", 32'h5A3); expect_v("same_addr_rd2", 32'h5A3);
      #1; compare(32'(i0.rd_data_1)); compare(32'(i0.rd_data_2));

      // Registered bypass on row 4
      @(negedge clk);
      wr0(1'b1, 3'd4, 11'h123); i0.rd_addr_1 = 3'd4;
      expect_v("comb_row4_old", 32'd0); expect_v("reg_before_edge", 32'h5A3);
      #1; compare(32'(i0.rd_data_1)); compare(32'(i1.rd_data_1));
      @(negedge clk);
      wr0(1'b0, 3'd0, 11'd0);
      expect_v("reg_bypass_row4", 32'h123); expect_v("comb_row4", 32'h123);
      #1; compare(32'(i1.rd_data_1)); compare(32'(i0.rd_data_1));

      // Fill, then full clear with a rejected write mid-sequence
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         wr0(1'b1, 3'(r), fv(r));
      end
      @(negedge clk);
      wr0(1'b0, 3'd0, 11'd0); i0.clr_req = 1'b1; i0.dbg_addr = 3'd5;
      expect_v("fill_dbg5", 32'(fv(5)));
      #1; compare(32'(i0.dbg_data));
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         i0.clr_req = 1'b0;
         wr0(k == 4, 3'd1, 11'h0AA);
         i0.rd_addr_1 = 3'd0; i0.rd_addr_2 = 3'd6;
         expect_v($sformatf("clr_busy_k%0d", k), 32'(k <= 9));
         expect_v($sformatf("clr_done_k%0d", k), 32'(k == 9));
         expect_v($sformatf("wr_err_k%0d", k), 32'(k == 4));
         #1; compare(32'(i0.clr_busy)); compare(32'(i0.clr_done)); compare(32'(i0.wr_err));
         if (k == 3) begin
            expect_v("clr_rd_cleared", 32'd0); expect_v("clr_rd_pending", 32'(fv(6)));
            compare(32'(i0.rd_data_1)); compare(32'(i0.rd_data_2));
         end
      end
      wr0(1'b0, 3'd0, 11'd0);
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         i0.dbg_addr = 3'(r);
         expect_v($sformatf("cleared_row%0d", r), 32'd0);
         expect_v($sformatf("cleared_reg_row%0d", r), 32'd0);
         #1; compare(32'(i0.dbg_data)); compare(32'(i1.dbg_data));
      end

      // Held request: ignored while busy, restarts after IDLE
      @(negedge clk);
      i0.clr_req = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         expect_v($sformatf("hold_busy_k%0d", k), 32'(k != 10));
         #1; compare(32'(i0.clr_busy));
      end
      i0.clr_req = 1'b0;
      wait_idle0("hold_idle");

      // Write and clear request on the same edge
      @(negedge clk);
      wr0(1'b1, 3'd3, 11'h3C3); i0.clr_req = 1'b1; i0.dbg_addr = 3'd3;
      expect_v("wrclr_werr", 32'd0);
      #1; compare(32'(i0.wr_err));
      @(negedge clk);
      wr0(1'b0, 3'd0, 11'd0); i0.clr_req = 1'b0;
      expect_v("wrclr_row3", 32'h3C3); expect_v("wrclr_busy", 32'd1);
      #1; compare(32'(i0.dbg_data)); compare(32'(i0.clr_busy));
      wait_idle0("wrclr_idle");
      expect_v("wrclr_row3_cleared", 32'd0);
      compare(32'(i0.dbg_data));

      // Reset asserted in the third CLEAR cycle
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         wr0(1'b1, 3'(r), fv(r));
      end
      @(negedge clk);
      wr0(1'b0, 3'd0, 11'd0); i0.clr_req = 1'b1; i0.rd_addr_1 = 3'd6;
      @(negedge clk);
      i0.clr_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      expect_v("rstmid_busy", 32'd0); expect_v("rstmid_done", 32'd0); expect_v("rstmid_rdreg", 32'd0);
      #1; compare(32'(i0.clr_busy)); compare(32'(i0.clr_done)); compare(32'(i1.rd_data_1));
      for (int r = 0; r < 8; r++) begin
         i0.dbg_addr = 3'(r);
         expect_v($sformatf("rstmid_row%0d", r), 32'd0);
         #1; compare(32'(i0.dbg_data));
      end
      @(negedge clk);
      reset = 1'b1;
      wr0(1'b1, 3'd5, 11'h155); i0.dbg_addr = 3'd5;
      @(negedge clk);
      wr0(1'b0, 3'd0, 11'd0);
      expect_v("post_rst_wr", 32'h155);
      #1; compare(32'(i0.dbg_data));
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         expect_v($sformatf("no_done_k%0d", k), 32'd0);
         #1; compare(32'(i0.clr_done));
      end

      // Wide variant: 16-bit data, 32 rows
      @(negedge clk);
      i2.wr_en = 1'b1; i2.wr_addr = 5'd31; i2.wr_data = 16'hBEEF;
      i2.rd_addr_1 = 5'd31; i2.rd_addr_2 = 5'd31;
      @(negedge clk);
      i2.wr_en = 1'b0;
      expect_v("wide_rd1", 32'hBEEF); expect_v("wide_rd2", 32'hBEEF);
      #1; compare(32'(i2.rd_data_1)); compare(32'(i2.rd_data_2));
      @(negedge clk);
      i2.clr_req = 1'b1;
      @(negedge clk);
      i2.clr_req = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (i2.clr_busy) busy_cnt++;
         if (i2.clr_done) done_cnt++;
         @(negedge clk);
      end
      expect_v("wide_busy_cycles", 32'd33); expect_v("wide_done_pulses", 32'd1); expect_v("wide_row31_cleared", 32'd0);
      #1; compare(32'(busy_cnt)); compare(32'(done_cnt)); compare(32'(i2.rd_data_1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
